// File: rtl/load_store_unit.sv
// Sized RV64 load/store engine in front of a doubleword-wide data memory.
// Loads are extended from the low 1/2/4/8 bytes of the read doubleword;
// sub-doubleword stores merge into the read doubleword before one write.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        ls_read,
    input  logic        ls_write,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [63:0] load_data,
    output logic        fault,
    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [63:0] Read_Data
);

    localparam int unsigned XLEN = 64;
    localparam logic [XLEN-1:0] MAX_ADDR = XLEN'(MEM_BYTES - 8);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RMW_READ = 3'd2,
        S_WRITE    = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              req_fault_q, req_fault_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic              fault_q, fault_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   write_data_q, write_data_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic              accept_c;
    logic              req_fault_c;

    // Extend the low 1/2/4/8 bytes of a read doubleword; bit 2 of funct3 selects zero-extension.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] rd, input logic [2:0] f3);
        logic [XLEN-1:0] res;
        case (f3[1:0])
            2'd0:    res = f3[2] ? {56'd0, rd[7:0]}  : {{56{rd[7]}},  rd[7:0]};
            2'd1:    res = f3[2] ? {48'd0, rd[15:0]} : {{48{rd[15]}}, rd[15:0]};
            2'd2:    res = f3[2] ? {32'd0, rd[31:0]} : {{32{rd[31]}}, rd[31:0]};
            default: res = rd;
        endcase
        return res;
    endfunction

    // Replace the low 1/2/4 bytes of the read doubleword with store data.
    function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] rd, input logic [XLEN-1:0] sd,
                                              input logic [1:0] sz);
        logic [XLEN-1:0] res;
        case (sz)
            2'd0:    res = {rd[63:8],  sd[7:0]};
            2'd1:    res = {rd[63:16], sd[15:0]};
            2'd2:    res = {rd[63:32], sd[31:0]};
            default: res = sd;
        endcase
        return res;
    endfunction

    // Request acceptance and fault classification.
    always_comb begin
        accept_c    = (state_q == S_IDLE) && req_valid && (ls_read || ls_write);
        req_fault_c = (ls_read && ls_write)
                   || (ls_read && (funct3 == 3'b111))
                   || (ls_write && funct3[2])
                   || (addr > MAX_ADDR);
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;
        req_fault_d = req_fault_q;
        load_data_d = load_data_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    addr_d      = addr;
                    funct3_d    = funct3;
                    wdata_d     = store_data;
                    req_fault_d = req_fault_c;
                    if (req_fault_c) begin
                        state_d = S_RESP;
                    end else if (ls_read) begin
                        state_d = S_LOAD;
                    end else if (funct3[1:0] == 2'd3) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RMW_READ;
                    end
                end
            end
            S_LOAD: begin
                load_data_d = extend(Read_Data, funct3_q);
                state_d     = S_RESP;
            end
            S_RMW_READ: begin
                wdata_d = merge(Read_Data, wdata_q, funct3_q[1:0]);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        resp_valid_d = (state_d == S_RESP);
        fault_d      = (state_d == S_RESP) && req_fault_d;
        mem_read_d   = (state_d == S_LOAD) || (state_d == S_RMW_READ);
        mem_write_d  = (state_d == S_WRITE);
        mem_addr_d   = (mem_read_d || mem_write_d) ? addr_d : mem_addr_q;
        write_data_d = mem_write_d ? wdata_d : write_data_q;
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            req_fault_q  <= 1'b0;
            load_data_q  <= '0;
            fault_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            mem_addr_q   <= '0;
            write_data_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            req_fault_q  <= req_fault_d;
            load_data_q  <= load_data_d;
            fault_q      <= fault_d;
            resp_valid_q <= resp_valid_d;
            mem_addr_q   <= mem_addr_d;
            write_data_q <= write_data_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    // Port drive; stall must see an incoming request in the same cycle.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        stall      = (state_q == S_LOAD) || (state_q == S_RMW_READ) || (state_q == S_WRITE) || accept_c;
        resp_valid = resp_valid_q;
        load_data  = load_data_q;
        fault      = fault_q;
        Mem_Addr   = mem_addr_q;
        Write_Data = write_data_q;
        MemRead    = mem_read_q;
        MemWrite   = mem_write_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model predicts
// each response; a negedge monitor compares whenever resp_valid is seen.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        ls_read;
    logic        ls_write;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [63:0] load_data;
    logic        fault;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] Read_Data;

    load_store_unit #(.MEM_BYTES(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .ls_read    (ls_read),
        .ls_write   (ls_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .req_ready  (req_ready),
        .stall      (stall),
        .resp_valid (resp_valid),
        .load_data  (load_data),
        .fault      (fault),
        .Mem_Addr   (Mem_Addr),
        .Write_Data (Write_Data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_Data  (Read_Data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        flt;
        int          acc;
        int          lat;
        int          reads;
        int          writes;
        logic        gold_en;
        logic [63:0] gold;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem     [64];
    logic [7:0]  ref_mem [64];
    logic [63:0] model_last;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_total = 0;
    int          txn_r = 0;
    int          txn_w = 0;

    // Data memory seen by the DUT: combinational read, write on the clock edge.
    always_comb begin
        logic [63:0] a;
        Read_Data = '0;
        for (int i = 0; i < 8; i++) begin
            a = Mem_Addr + 64'(i);
            if (a < 64'd64) Read_Data[i*8 +: 8] = mem[a[5:0]];
        end
    end

    always @(posedge clk) begin
        if (MemWrite) begin
            for (int i = 0; i < 8; i++) begin
                if (Mem_Addr + 64'(i) < 64'd64) mem[int'(Mem_Addr[5:0]) + i] <= Write_Data[i*8 +: 8];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=0x%016h expected=0x%016h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: applies one request to the byte array and predicts its response.
    task automatic model_req(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [63:0] a, input logic [63:0] sd, output exp_t e);
        int          n;
        logic [63:0] v;
        logic [63:0] msk;
        n = 1 << f3[1:0];
        e.gold_en = 1'b0;
        e.gold    = '0;
        if ((rd && wr) || (rd && f3 == 3'b111) || (wr && f3[2]) || (a > 64'd56)) begin
            e.flt = 1'b1; e.lat = 1; e.reads = 0; e.writes = 0;
        end else if (rd) begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(a[5:0]) + i]) << (8 * i));
            msk = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
            if (!f3[2] && v[8 * n - 1]) v = v | ~msk;
            model_last = v;
            e.flt = 1'b0; e.lat = 2; e.reads = 1; e.writes = 0;
        end else begin
            for (int i = 0; i < n; i++) ref_mem[int'(a[5:0]) + i] = sd[i*8 +: 8];
            e.flt = 1'b0; e.lat = (n == 8) ? 2 : 3; e.reads = (n == 8) ? 0 : 1; e.writes = 1;
        end
        e.data = model_last;
    endtask

    // Present one request, hold it until accepted, and queue the prediction.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] sd, input logic gold_en, input logic [63:0] gold);
        exp_t e;
        int   waited;
        @(negedge clk);
        req_valid = 1'b1; ls_read = rd; ls_write = wr; funct3 = f3; addr = a; store_data = sd;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout req_ready=%0b after %0d cycles, required 1", req_ready, waited);
            req_valid = 1'b0;
            return;
        end
        model_req(rd, wr, f3, a, sd, e);
        e.acc     = cyc;
        e.gold_en = gold_en;
        e.gold    = gold;
        @(posedge clk);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0; ls_read = 1'b0; ls_write = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check64({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check64({tag, "_load_data"},  load_data,       64'd0);
        check64({tag, "_fault"},      64'(fault),      64'd0);
        check64({tag, "_mem_addr"},   Mem_Addr,        64'd0);
        check64({tag, "_write_data"}, Write_Data,      64'd0);
        check64({tag, "_memread"},    64'(MemRead),    64'd0);
        check64({tag, "_memwrite"},   64'(MemWrite),   64'd0);
    endtask

    // Monitor: count memory activity per transaction, compare each response with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                txn_r = 0; txn_w = 0;
            end else begin
                if (MemRead) txn_r++;
                if (MemWrite) begin txn_w++; wr_total++; end
                if (resp_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_resp resp_valid=1 with no request outstanding (cycle %0d)", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check64("load_data", load_data, e.data);
                        check64("fault", 64'(fault), 64'(e.flt));
                        check64("latency", 64'(cyc - e.acc), 64'(e.lat));
                        check64("memread_cycles", 64'(txn_r), 64'(e.reads));
                        check64("memwrite_pulses", 64'(txn_w), 64'(e.writes));
                        check64("stall_in_resp", 64'(stall), 64'd0);
                        check64("req_ready_in_resp", 64'(req_ready), 64'd0);
                        if (e.gold_en) check64("golden_load", load_data, e.gold);
                    end
                    txn_r = 0; txn_w = 0;
                end
            end
        end
    end

    initial begin
        int snap;
        int waited;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = (i < 53) ? 8'(i + 9) : 8'd0;
            ref_mem[i] = (i < 53) ? 8'(i + 9) : 8'd0;
        end
        model_last = '0;
        reset_n = 1'b0; req_valid = 1'b0; ls_read = 1'b0; ls_write = 1'b0;
        funct3 = '0; addr = '0; store_data = '0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check64("req_ready_idle", 64'(req_ready), 64'd1);

        // Plain doubleword load from address 0.
        issue(1'b1, 1'b0, 3'b011, 64'd0, 64'd0, 1'b1, 64'h100F0E0D0C0B0A09);
        idle(3);

        // Reset while an SB sits in RMW_READ: outputs clear at once, no write follows.
        @(negedge clk);
        req_valid = 1'b1; ls_read = 1'b0; ls_write = 1'b1; funct3 = 3'b000; addr = 64'd0; store_data = 64'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; ls_write = 1'b0;
        check64("rmw_read_active", 64'(MemRead), 64'd1);
        snap = wr_total;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        model_last = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(4);
        check64("no_write_after_reset", 64'(wr_total), 64'(snap));
        issue(1'b1, 1'b0, 3'b011, 64'd0, 64'd0, 1'b1, 64'h100F0E0D0C0B0A09);

        // Ignored requests: neither load nor store.
        idle(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1; ls_read = 1'b0; ls_write = 1'b0; addr = 64'd8;
            check64("ignored_stall", 64'(stall), 64'd0);
            check64("ignored_req_ready", 64'(req_ready), 64'd1);
            check64("ignored_memread", 64'(MemRead), 64'd0);
        end
        idle(1);

        // Byte, half and word stores followed by reads of the merged data.
        issue(1'b0, 1'b1, 3'b000, 64'd8,  64'h80, 1'b0, 64'd0);
        issue(1'b1, 1'b0, 3'b000, 64'd8,  64'd0,  1'b1, 64'hFFFFFFFFFFFFFF80);
        issue(1'b1, 1'b0, 3'b100, 64'd8,  64'd0,  1'b1, 64'h0000000000000080);
        issue(1'b1, 1'b0, 3'b011, 64'd8,  64'd0,  1'b1, 64'h1817161514131280);
        issue(1'b0, 1'b1, 3'b001, 64'd16, 64'hBEEF, 1'b0, 64'd0);
        issue(1'b1, 1'b0, 3'b001, 64'd16, 64'd0,  1'b1, 64'hFFFFFFFFFFFFBEEF);
        issue(1'b1, 1'b0, 3'b011, 64'd16, 64'd0,  1'b1, 64'h201F1E1D1C1BBEEF);
        issue(1'b1, 1'b0, 3'b010, 64'd40, 64'd0,  1'b1, 64'h0000000034333231);
        issue(1'b0, 1'b1, 3'b010, 64'd0,  64'h80000000, 1'b0, 64'd0);
        issue(1'b1, 1'b0, 3'b110, 64'd0,  64'd0,  1'b1, 64'h0000000080000000);
        issue(1'b1, 1'b0, 3'b010, 64'd0,  64'd0,  1'b1, 64'hFFFFFFFF80000000);

        // Fault cases and address boundary.
        issue(1'b1, 1'b0, 3'b000, 64'd57, 64'd0, 1'b0, 64'd0);
        issue(1'b0, 1'b1, 3'b100, 64'd0,  64'd0, 1'b0, 64'd0);
        issue(1'b1, 1'b1, 3'b011, 64'd0,  64'd0, 1'b0, 64'd0);
        issue(1'b1, 1'b0, 3'b111, 64'd0,  64'd0, 1'b0, 64'd0);
        issue(1'b1, 1'b0, 3'b011, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 64'd0);
        issue(1'b1, 1'b0, 3'b011, 64'd56, 64'd0, 1'b1, 64'd0);
        issue(1'b0, 1'b1, 3'b011, 64'd56, 64'hA1B2C3D4E5F60718, 1'b0, 64'd0);
        issue(1'b1, 1'b0, 3'b011, 64'd56, 64'd0, 1'b1, 64'hA1B2C3D4E5F60718);

        // Randomized back-to-back traffic.
        for (int i = 0; i < 250; i++) begin
            int          r;
            logic        rd;
            logic        wr;
            logic [63:0] a;
            r  = int'($urandom_range(0, 99));
            rd = (r < 50) || (r >= 95);
            wr = (r >= 50);
            r  = int'($urandom_range(0, 99));
            if (r < 85)      a = 64'($urandom_range(0, 56));
            else if (r < 97) a = 64'($urandom_range(50, 63));
            else             a = {32'($urandom), 32'($urandom)} | 64'h1_0000_0000;
            issue(rd, wr, 3'($urandom_range(0, 7)), a, {32'($urandom), 32'($urandom)}, 1'b0, 64'd0);
            if ($urandom_range(0, 15) == 0) idle(int'($urandom_range(1, 3)));
        end

        // Drain outstanding responses, then compare the whole memory image.
        idle(1);
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout outstanding=%0d, required 0", exp_q.size());
        end
        idle(2);
        for (int i = 0; i < 64; i++) check64($sformatf("mem_byte_%0d", i), 64'(mem[i]), 64'(ref_mem[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
